light_switch_ctrl: RTL and testbench

Front-end for the hood light control. Takes the raw light pushbutton, synchronises and debounces it, and classifies each press as short or long. It then drives the level-type light request `light_sw` that the light output stage consumes, gated by the hood power state `machine_state`. It sits between the board button pin and the light output block.

---
 rtl/light_switch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_light_switch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/light_switch_ctrl.sv
// Hood light pushbutton front-end.
// Synchronises and debounces the raw button, classifies each press as short
// or long, and drives the registered light request gated by the hood power
// state. Reset is synchronous and active-high.
module light_switch_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 2000000,
  parameter int LONG_PRESS_CYCLES = 200000000,
  parameter int CNT_W             = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic machine_state,
  output logic light_sw,
  output logic btn_stable,
  output logic press_pulse,
  output logic long_press_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_q1;
  logic             btn_sync;
  logic [1:0]       sync_fill;
  logic [CNT_W-1:0] deb_cnt;
  logic             armed;
  logic [CNT_W-1:0] hold_cnt;
  state_t           state_q;
  state_t           state_d;
  logic             short_fire;
  logic             long_fire;
  logic             hold_clr;

  // Two-flop synchroniser; sync_fill marks when btn_sync holds a real sample.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the chain really is two
    // stages deep instead of collapsing into one).
    if (rst) begin
      sync_q1   <= 1'b0;
      btn_sync  <= 1'b0;
      sync_fill <= 2'b00;
    end else begin
      sync_q1   <= btn_raw;
      btn_sync  <= sync_q1;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt    <= '0;
      btn_stable <= 1'b0;
    end else if (btn_sync == btn_stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_stable <= btn_sync;
      deb_cnt    <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_ONE;
    end
  end

  // Arm press detection only once the button has been seen released after
  // reset, so a button held through reset is not taken as a new press.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (sync_fill[1] && !btn_sync && !btn_stable) begin
      armed <= 1'b1;
    end
  end

  // Press classifier state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Press classifier next-state and fire decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    short_fire = 1'b0;
    long_fire  = 1'b0;
    hold_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        hold_clr = 1'b1;
        if (btn_stable && armed) begin
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!btn_stable) begin
          state_d    = IDLE;
          short_fire = 1'b1;
        end else if (hold_cnt == LONG_LAST) begin
          state_d   = HELD;
          long_fire = 1'b1;
        end
      end
      HELD: begin
        if (!btn_stable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold counter: cleared while idle, saturating while the button is down.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (hold_clr) begin
      hold_cnt <= '0;
    end else if (hold_cnt != CNT_MAX) begin
      hold_cnt <= hold_cnt + CNT_ONE;
    end
  end

  // One-cycle press strobes, registered from the classifier decisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_pulse      <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      press_pulse      <= short_fire;
      long_press_pulse <= long_fire;
    end
  end

  // Light request: power-off and long press force off, short press toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      light_sw <= 1'b0;
    end else if (!machine_state || long_fire) begin
      light_sw <= 1'b0;
    end else if (short_fire) begin
      light_sw <= ~light_sw;
    end
  end

endmodule

// File: tb/tb_light_switch_ctrl.sv
// Self-checking bench for light_switch_ctrl with small debounce/long-press
// thresholds. Run-length vector table plus hand-written latency sequences.
module tb_light_switch_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int CW   = 8;

  logic clk;
  logic rst;
  logic btn_raw;
  logic machine_state;
  logic light_sw;
  logic btn_stable;
  logic press_pulse;
  logic long_press_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string name;
    logic  rst;
    logic  btn;
    logic  ms;
    int    n;          // cycles to hold these inputs
    logic  exp_light;  // outputs expected after the last cycle
    logic  exp_stable;
    logic  exp_press;
    logic  exp_long;
    int    exp_np;     // press_pulse cycles seen during the segment
    int    exp_nl;     // long_press_pulse cycles seen during the segment
  } vec_t;

  vec_t vecs[$];

  light_switch_ctrl #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .CNT_W            (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_raw         (btn_raw),
    .machine_state   (machine_state),
    .light_sw        (light_sw),
    .btn_stable      (btn_stable),
    .press_pulse     (press_pulse),
    .long_press_pulse(long_press_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic add(input string name, input logic r, input logic b, input logic m,
                     input int n, input logic l, input logic s, input logic p,
                     input logic lg, input int np, input int nl);
    vec_t v;
    v.name = name; v.rst = r; v.btn = b; v.ms = m; v.n = n;
    v.exp_light = l; v.exp_stable = s; v.exp_press = p; v.exp_long = lg;
    v.exp_np = np; v.exp_nl = nl;
    vecs.push_back(v);
  endtask

  // One clock: inputs already driven, sample outputs 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    check("pulse_exclusive", int'(press_pulse & long_press_pulse), 0);
  endtask

  initial begin
    int np;
    int nl;
    int cyc;

    rst = 1'b1;
    btn_raw = 1'b0;
    machine_state = 1'b1;

    //   name              rst btn ms  n   light stab press long np nl
    add("reset",            1,  0,  1,  3,  0,    0,   0,    0,   0, 0);
    // 1: short presses toggle the light; stable edge lands 6 cycles after raw.
    add("t1_idle",          0,  0,  1,  4,  0,    0,   0,    0,   0, 0);
    add("t1_raw_rise_5",    0,  1,  1,  5,  0,    0,   0,    0,   0, 0);
    add("t1_stable_rise",   0,  1,  1,  1,  0,    1,   0,    0,   0, 0);
    add("t1_hold",          0,  1,  1,  4,  0,    1,   0,    0,   0, 0);
    add("t1_rel_5",         0,  0,  1,  5,  0,    1,   0,    0,   0, 0);
    add("t1_stable_fall",   0,  0,  1,  1,  0,    0,   0,    0,   0, 0);
    add("t1_press1",        0,  0,  1,  1,  1,    0,   1,    0,   1, 0);
    add("t1_after1",        0,  0,  1,  1,  1,    0,   0,    0,   0, 0);
    add("t1_p2_rise",       0,  1,  1,  6,  1,    1,   0,    0,   0, 0);
    add("t1_p2_hold",       0,  1,  1,  4,  1,    1,   0,    0,   0, 0);
    add("t1_p2_rel",        0,  0,  1,  6,  1,    0,   0,    0,   0, 0);
    add("t1_press2",        0,  0,  1,  1,  0,    0,   1,    0,   1, 0);
    add("t1_after2",        0,  0,  1,  1,  0,    0,   0,    0,   0, 0);
    // 2: 3-cycle glitches never reach the 4-sample threshold.
    for (int i = 0; i < 5; i++) begin
      add("t2_glitch_hi",   0,  1,  1,  3,  0,    0,   0,    0,   0, 0);
      add("t2_glitch_lo",   0,  0,  1,  2,  0,    0,   0,    0,   0, 0);
    end
    add("t2_settle",        0,  0,  1,  6,  0,    0,   0,    0,   0, 0);
    // 3: light on, then a 40-cycle hold forces it off with one long pulse.
    add("t3_pre_hi",        0,  1,  1, 10,  0,    1,   0,    0,   0, 0);
    add("t3_pre_lo",        0,  0,  1,  7,  1,    0,   1,    0,   1, 0);
    add("t3_pre_gap",       0,  0,  1,  2,  1,    0,   0,    0,   0, 0);
    add("t3_long_wait",     0,  1,  1, 26,  1,    1,   0,    0,   0, 0);
    add("t3_long_pulse",    0,  1,  1,  1,  0,    1,   0,    1,   0, 1);
    add("t3_long_hold",     0,  1,  1, 13,  0,    1,   0,    0,   0, 0);
    add("t3_release",       0,  0,  1, 10,  0,    0,   0,    0,   0, 0);
    // 4: power off still pulses but keeps light off; dropping power kills light.
    add("t4_ms0_hi",        0,  1,  0, 10,  0,    1,   0,    0,   0, 0);
    add("t4_ms0_lo",        0,  0,  0,  7,  0,    0,   1,    0,   1, 0);
    add("t4_ms0_hold",      0,  0,  0,  3,  0,    0,   0,    0,   0, 0);
    add("t4_on_hi",         0,  1,  1, 10,  0,    1,   0,    0,   0, 0);
    add("t4_on_lo",         0,  0,  1,  7,  1,    0,   1,    0,   1, 0);
    add("t4_on_gap",        0,  0,  1,  2,  1,    0,   0,    0,   0, 0);
    add("t4_ms_drop",       0,  0,  0,  1,  0,    0,   0,    0,   0, 0);
    // 5: reset mid-press; held button after reset is ignored until re-pressed.
    add("t5_press8",        0,  1,  1,  8,  0,    1,   0,    0,   0, 0);
    add("t5_reset",         1,  1,  1,  2,  0,    0,   0,    0,   0, 0);
    add("t5_held_after",    0,  1,  1, 30,  0,    1,   0,    0,   0, 0);
    add("t5_release",       0,  0,  1, 10,  0,    0,   0,    0,   0, 0);
    add("t5_new_hi",        0,  1,  1, 10,  0,    1,   0,    0,   0, 0);
    add("t5_new_lo",        0,  0,  1,  7,  1,    0,   1,    0,   1, 0);
    add("t5_gap",           0,  0,  1,  2,  1,    0,   0,    0,   0, 0);
    // 6: power falls in the press_pulse cycle with light off: stays off.
    add("t6_off",           0,  0,  0,  1,  0,    0,   0,    0,   0, 0);
    add("t6_hi",            0,  1,  1, 10,  0,    1,   0,    0,   0, 0);
    add("t6_lo",            0,  0,  1,  6,  0,    0,   0,    0,   0, 0);
    add("t6_drop",          0,  0,  0,  1,  0,    0,   1,    0,   1, 0);
    add("t6_after",         0,  0,  1,  2,  0,    0,   0,    0,   0, 0);

    foreach (vecs[i]) begin
      np = 0;
      nl = 0;
      rst = vecs[i].rst;
      btn_raw = vecs[i].btn;
      machine_state = vecs[i].ms;
      for (int c = 0; c < vecs[i].n; c++) begin
        step();
        np += int'(press_pulse);
        nl += int'(long_press_pulse);
      end
      check({vecs[i].name, ".light_sw"},   int'(light_sw),         int'(vecs[i].exp_light));
      check({vecs[i].name, ".btn_stable"}, int'(btn_stable),       int'(vecs[i].exp_stable));
      check({vecs[i].name, ".press"},      int'(press_pulse),      int'(vecs[i].exp_press));
      check({vecs[i].name, ".long"},       int'(long_press_pulse), int'(vecs[i].exp_long));
      check({vecs[i].name, ".n_press"},    np,                     vecs[i].exp_np);
      check({vecs[i].name, ".n_long"},     nl,                     vecs[i].exp_nl);
    end

    // Hand sequence: measured latencies. Raw edge -> stable is DEB+2 edges;
    // PRESSED is entered one edge after stable rises, the counter then runs
    // 0..LONG-1 and the pulse registers one edge later: LONG+1 edges.
    machine_state = 1'b1;
    btn_raw = 1'b1;
    cyc = 0;
    while (cyc < 50 && !btn_stable) begin
      step();
      cyc++;
    end
    check("lat_stable_rise", cyc, DEB + 2);
    cyc = 0;
    while (cyc < 60 && !long_press_pulse) begin
      step();
      cyc++;
    end
    check("lat_long_pulse", cyc, LONG + 1);
    step();
    check("long_pulse_width", int'(long_press_pulse), 0);
    nl = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      nl += int'(long_press_pulse);
    end
    check("long_pulse_once", nl, 0);

    btn_raw = 1'b0;
    cyc = 0;
    while (cyc < 50 && btn_stable) begin
      step();
      cyc++;
    end
    check("lat_stable_fall", cyc, DEB + 2);
    np = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      np += int'(press_pulse);
    end
    check("held_release_no_press", np, 0);
    check("held_release_light", int'(light_sw), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
